// File: rtl/iq_freq_unshift_pkg.sv
// Shared types, constants and arithmetic helpers for the I/Q frequency de-rotator.
// The quarter-wave sine table is built at elaboration time from a Taylor series.
package iq_freq_unshift_pkg;

  localparam int PHASE_W_DEF    = 16;
  localparam int LUT_ADDR_W_DEF = 10;
  localparam int QW_AW          = 8;
  localparam int QW_DEPTH       = 1 << QW_AW;
  localparam int PIPE_LAT       = 5;

  typedef logic signed [15:0] sample_t;

  typedef struct packed {
    sample_t i;
    sample_t q;
  } cplx_t;

  localparam sample_t QW_MAX = 16'sd32767;

  typedef logic [QW_DEPTH-1:0][15:0] qw_lut_t;

  // Entry j = round(32767 * sin(pi/2 * j/256)); the series converges well inside [0, pi/2].
  function automatic qw_lut_t gen_qw_lut();
    qw_lut_t t;
    real     x;
    real     term;
    real     sum;
    t = '0;
    for (int j = 0; j < QW_DEPTH; j++) begin
      x    = 3.14159265358979323846 / 2.0 * real'(j) / real'(QW_DEPTH);
      term = x;
      sum  = x;
      for (int k = 1; k < 12; k++) begin
        term = -term * x * x / real'((2 * k) * (2 * k + 1));
        sum  = sum + term;
      end
      t[j] = 16'(int'(32767.0 * sum));
    end
    return t;
  endfunction

  localparam qw_lut_t QW_LUT = gen_qw_lut();

  // Round half-up at bit 15, then clamp to the Q1.15 range.
  function automatic sample_t round_sat(input logic signed [32:0] v);
    logic signed [33:0] r;
    r = {v[32], v} + 34'sd16384;
    r = r >>> 15;
    if (r > 34'sd32767) begin
      return 16'sh7fff;
    end else if (r < -34'sd32768) begin
      return 16'sh8000;
    end
    return signed'(r[15:0]);
  endfunction

endpackage

// File: rtl/iq_freq_unshift_if.sv
// Streaming port bundle for the de-rotator: lane-packed I/Q in and out.
// in_valid qualifies a beat and is always accepted (no ready); out_valid qualifies
// data_out, which holds its previous value while out_valid is low.
interface iq_freq_unshift_if
  import iq_freq_unshift_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int PHASE_W        = PHASE_W_DEF
);
  logic [16*NUMBER_OF_LINE-1:0] data_in_i;
  logic [16*NUMBER_OF_LINE-1:0] data_in_q;
  logic                         in_valid;
  logic [PHASE_W-1:0]           dds_phase_inc;
  logic                         phase_inc_load;
  logic                         phase_clear;
  logic [16*NUMBER_OF_LINE-1:0] data_out_i;
  logic [16*NUMBER_OF_LINE-1:0] data_out_q;
  logic                         out_valid;

  modport master (
    output data_in_i, data_in_q, in_valid, dds_phase_inc, phase_inc_load, phase_clear,
    input  data_out_i, data_out_q, out_valid
  );

  modport slave (
    input  data_in_i, data_in_q, in_valid, dds_phase_inc, phase_inc_load, phase_clear,
    output data_out_i, data_out_q, out_valid
  );
endinterface

// File: rtl/nco_sincos_lane.sv
// Phase to sin/cos lookup: registered address, then registered quadrant-mapped
// quarter-wave table output (two cycles from phase to sin_out/cos_out).
module nco_sincos_lane
  import iq_freq_unshift_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PHASE_W-1:0] phase,
  output sample_t            sin_out,
  output sample_t            cos_out
);

  logic [LUT_ADDR_W-1:0] addr;
  logic [1:0]            quad;
  logic [QW_AW-1:0]      j;
  logic [QW_AW-1:0]      j_mirror;
  sample_t               sin_p;
  sample_t               cos_p;
  sample_t               sin_n;
  sample_t               cos_n;
  logic                  unused_phase_lsbs;

  assign unused_phase_lsbs = ^phase[PHASE_W-LUT_ADDR_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      addr <= '0;
    end else begin
      addr <= phase[PHASE_W-1 -: LUT_ADDR_W];
    end
  end

  assign quad     = addr[LUT_ADDR_W-1 -: 2];
  assign j        = addr[LUT_ADDR_W-3 -: QW_AW];
  assign j_mirror = ~j + QW_AW'(1);

  // cos(phi) = sin(pi/2 - phi); the j == 0 point falls off the end of the table.
  always_comb begin
    sin_p = signed'(QW_LUT[j]);
    cos_p = (j == '0) ? QW_MAX : signed'(QW_LUT[j_mirror]);
    sin_n = '0;
    cos_n = '0;
    case (quad)
      2'd0: begin sin_n = sin_p;  cos_n = cos_p;  end
      2'd1: begin sin_n = cos_p;  cos_n = -sin_p; end
      2'd2: begin sin_n = -sin_p; cos_n = -cos_p; end
      default: begin sin_n = -cos_p; cos_n = sin_p; end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sin_out <= '0;
      cos_out <= '0;
    end else begin
      sin_out <= sin_n;
      cos_out <= cos_n;
    end
  end

endmodule

// File: rtl/iq_freq_unshift.sv
// Multi-lane receive-side de-rotator: y[n] = x[n] * exp(-j*theta[n]) with a parallel
// phase accumulator, per-lane sin/cos lookup and a conjugate complex multiply.
module iq_freq_unshift
  import iq_freq_unshift_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int PHASE_W        = PHASE_W_DEF,
  parameter int LUT_ADDR_W     = LUT_ADDR_W_DEF
) (
  input logic             clock,
  input logic             reset,
  iq_freq_unshift_if.slave bus
);

  logic [PHASE_W-1:0]  acc;
  logic [PHASE_W-1:0]  inc_active;
  logic [PHASE_W-1:0]  base;
  logic [PIPE_LAT:0]   vld;

  always_comb begin
    base = bus.phase_clear ? '0 : acc;
  end

  // A load in the same cycle as a beat only takes effect for the following beats.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc        <= '0;
      inc_active <= '0;
      vld        <= '0;
    end else begin
      vld <= {vld[PIPE_LAT-1:0], bus.in_valid};
      if (bus.phase_inc_load) begin
        inc_active <= bus.dds_phase_inc;
      end
      if (bus.in_valid) begin
        acc <= base + PHASE_W'(NUMBER_OF_LINE) * inc_active;
      end else if (bus.phase_clear) begin
        acc <= '0;
      end
    end
  end

  assign bus.out_valid = vld[PIPE_LAT];

  for (genvar k = 0; k < NUMBER_OF_LINE; k++) begin : g_lane
    logic [PHASE_W-1:0] ph_s0;
    cplx_t              d_s0;
    cplx_t              d_s1;
    cplx_t              d_s2;
    sample_t            sin_s2;
    sample_t            cos_s2;
    logic signed [31:0] p_ic;
    logic signed [31:0] p_qs;
    logic signed [31:0] p_qc;
    logic signed [31:0] p_is;
    logic signed [32:0] sum_i;
    logic signed [32:0] sum_q;
    sample_t            out_i;
    sample_t            out_q;

    nco_sincos_lane #(
      .PHASE_W    (PHASE_W),
      .LUT_ADDR_W (LUT_ADDR_W)
    ) u_nco (
      .clock   (clock),
      .reset   (reset),
      .phase   (ph_s0),
      .sin_out (sin_s2),
      .cos_out (cos_s2)
    );

    // Data is delayed two beats so it meets its sin/cos at S2; outputs only move on valid beats.
    always_ff @(posedge clock) begin
      if (reset) begin
        ph_s0 <= '0;
        d_s0  <= '0;
        d_s1  <= '0;
        d_s2  <= '0;
        p_ic  <= '0;
        p_qs  <= '0;
        p_qc  <= '0;
        p_is  <= '0;
        sum_i <= '0;
        sum_q <= '0;
        out_i <= '0;
        out_q <= '0;
      end else begin
        ph_s0  <= base + PHASE_W'(k) * inc_active;
        d_s0.i <= signed'(bus.data_in_i[16*k +: 16]);
        d_s0.q <= signed'(bus.data_in_q[16*k +: 16]);
        d_s1   <= d_s0;
        d_s2   <= d_s1;
        p_ic   <= 32'(d_s2.i) * 32'(cos_s2);
        p_qs   <= 32'(d_s2.q) * 32'(sin_s2);
        p_qc   <= 32'(d_s2.q) * 32'(cos_s2);
        p_is   <= 32'(d_s2.i) * 32'(sin_s2);
        sum_i  <= 33'(p_ic) + 33'(p_qs);
        sum_q  <= 33'(p_qc) - 33'(p_is);
        if (vld[PIPE_LAT-1]) begin
          out_i <= round_sat(sum_i);
          out_q <= round_sat(sum_q);
        end
      end
    end

    assign bus.data_out_i[16*k +: 16] = out_i;
    assign bus.data_out_q[16*k +: 16] = out_q;
  end

endmodule

// File: tb/tb_iq_freq_unshift.sv
// Bench for iq_freq_unshift: a phase/trig reference model pushes expected beats on
// drive; a monitor one step after each rising edge pops and compares them.
module tb_iq_freq_unshift;

  localparam int  N  = 8;
  localparam int  VW = 16 * N;
  localparam int  W  = 32 + 2 * VW;
  localparam real PI = 3.14159265358979323846;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  logic mon_en;

  logic [W-1:0]  exp_q[$];
  logic [15:0]   m_acc;
  logic [15:0]   m_inc;
  logic [VW-1:0] last_i;
  logic [VW-1:0] last_q;

  iq_freq_unshift_if #(.NUMBER_OF_LINE(N), .PHASE_W(16)) bus ();

  iq_freq_unshift #(
    .NUMBER_OF_LINE (N),
    .PHASE_W        (16),
    .LUT_ADDR_W     (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int rsat(input longint v);
    longint r;
    r = (v + 64'sd16384) >>> 15;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return int'(r);
  endfunction

  function automatic logic [VW-1:0] rep(input logic [15:0] x);
    return {N{x}};
  endfunction

  // driver: one cycle per call; pushes the expected beat and advances the phase model
  task automatic drive(input logic v, input logic [VW-1:0] di, input logic [VW-1:0] dq,
                       input logic clr, input logic ld, input logic [15:0] inc_val);
    logic [15:0]  base;
    logic [15:0]  ph;
    logic [9:0]   addr;
    real          ang;
    int           c;
    int           s;
    longint       xi;
    longint       xq;
    logic [W-1:0] e;
    @(negedge clock);
    bus.in_valid       = v;
    bus.data_in_i      = di;
    bus.data_in_q      = dq;
    bus.phase_clear    = clr;
    bus.phase_inc_load = ld;
    bus.dds_phase_inc  = inc_val;
    base = clr ? 16'h0000 : m_acc;
    if (v) begin
      e = '0;
      e[W-1 -: 32] = 32'(cyc + 6);
      for (int k = 0; k < N; k++) begin
        ph   = base + 16'(k) * m_inc;
        addr = ph[15:6];
        ang  = 2.0 * PI * real'(addr) / 1024.0;
        c    = int'(32767.0 * $cos(ang));
        s    = int'(32767.0 * $sin(ang));
        xi   = longint'($signed(di[16*k +: 16]));
        xq   = longint'($signed(dq[16*k +: 16]));
        e[VW + 16*k +: 16] = 16'(rsat(xi * c + xq * s));
        e[16*k +: 16]      = 16'(rsat(xq * c - xi * s));
      end
      exp_q.push_back(e);
      m_acc = base + 16'(N) * m_inc;
    end else if (clr) begin
      m_acc = 16'h0000;
    end
    if (ld) m_inc = inc_val;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic set_inc(input logic [15:0] inc_val);
    drive(1'b0, '0, '0, 1'b1, 1'b1, inc_val);
  endtask

  // scoreboard monitor
  always @(posedge clock) begin : monitor
    logic [W-1:0] e;
    logic         exp_v;
    #1;
    if (mon_en && !reset) begin
      exp_v = (exp_q.size() > 0) && (exp_q[0][W-1 -: 32] == 32'(cyc));
      check("out_valid", int'(bus.out_valid), int'(exp_v));
      if (exp_v) begin
        e = exp_q.pop_front();
        if (bus.out_valid) begin
          for (int k = 0; k < N; k++) begin
            check($sformatf("i_lane%0d", k), int'($signed(bus.data_out_i[16*k +: 16])),
                  int'($signed(e[VW + 16*k +: 16])));
            check($sformatf("q_lane%0d", k), int'($signed(bus.data_out_q[16*k +: 16])),
                  int'($signed(e[16*k +: 16])));
          end
        end
        last_i = e[VW +: VW];
        last_q = e[VW-1:0];
      end else if (!bus.out_valid) begin
        check("hold", int'((bus.data_out_i == last_i) && (bus.data_out_q == last_q)), 1);
      end
    end
  end

  initial begin
    logic [VW-1:0] ri;
    logic [VW-1:0] rq;
    logic          v;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    m_acc  = '0;
    m_inc  = '0;
    last_i = '0;
    last_q = '0;
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.data_in_i      = '0;
    bus.data_in_q      = '0;
    bus.phase_clear    = 1'b0;
    bus.phase_inc_load = 1'b0;
    bus.dds_phase_inc  = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(|{bus.data_out_i, bus.data_out_q}), 0);
    @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;

    // zero frequency
    set_inc(16'h0000);
    drive(1'b1, rep(16'd16384), rep(16'd0), 1'b1, 1'b0, 16'h0000);
    idle(7);
    drive(1'b1, rep(16'd16384), rep(16'd0), 1'b0, 1'b0, 16'h0000);
    drive(1'b1, rep(16'd16384), rep(16'd0), 1'b0, 1'b0, 16'h0000);

    // quarter rate
    set_inc(16'h4000);
    drive(1'b1, rep(16'd16384), rep(16'd0), 1'b1, 1'b0, 16'h0000);
    drive(1'b1, rep(16'd16384), rep(16'd0), 1'b0, 1'b0, 16'h0000);

    // accumulator wrap: lane0 phase 0x0000, 0x8000, 0x0000
    set_inc(16'h1000);
    drive(1'b1, rep(16'd16384), rep(16'd0), 1'b1, 1'b0, 16'h0000);
    drive(1'b1, rep(16'd16384), rep(16'd0), 1'b0, 1'b0, 16'h0000);
    drive(1'b1, rep(16'd16384), rep(16'd0), 1'b0, 1'b0, 16'h0000);

    // saturation at 45 degrees
    set_inc(16'h2000);
    drive(1'b1, rep(16'h8000), rep(16'h8000), 1'b1, 1'b0, 16'h0000);
    idle(2);

    // load with a beat uses old inc; clear with a beat gives base 0
    drive(1'b1, rep(16'd12000), rep(-16'sd7000), 1'b1, 1'b1, 16'h0800);
    drive(1'b1, rep(16'd12000), rep(-16'sd7000), 1'b0, 1'b0, 16'h0000);
    drive(1'b1, rep(16'd12000), rep(-16'sd7000), 1'b0, 1'b1, 16'h0c35);
    drive(1'b1, rep(16'd12000), rep(-16'sd7000), 1'b1, 1'b0, 16'h0000);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 16'h0000);
    drive(1'b1, rep(16'd12000), rep(-16'sd7000), 1'b0, 1'b0, 16'h0000);

    // random stream
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < N; k++) begin
        ri[16*k +: 16] = 16'($urandom_range(0, 65535));
        rq[16*k +: 16] = 16'($urandom_range(0, 65535));
      end
      v = ($urandom_range(0, 3) != 0);
      drive(v, ri, rq, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
            16'($urandom_range(0, 65535)));
    end
    idle(7);

    // reset with three beats in flight
    set_inc(16'h0300);
    for (int n = 0; n < 3; n++) drive(1'b1, rep(16'd9000), rep(16'd3000), 1'b0, 1'b0, 16'h0000);
    @(negedge clock);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    m_acc  = '0;
    m_inc  = '0;
    last_i = '0;
    last_q = '0;
    @(posedge clock);
    #1;
    check("midrst_valid", int'(bus.out_valid), 0);
    check("midrst_data", int'(|{bus.data_out_i, bus.data_out_q}), 0);
    @(negedge clock);
    reset = 1'b0;
    idle(8);

    // accumulator restarts from 0 without an explicit clear
    drive(1'b0, '0, '0, 1'b0, 1'b1, 16'h0400);
    for (int n = 0; n < 3; n++) drive(1'b1, rep(16'd20000), rep(-16'sd5000), 1'b0, 1'b0, 16'h0000);
    idle(10);

    check("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
